// File: rtl/uart_rx_frame_check.sv
// UART receive framing engine: oversampled 2-of-3 majority bit recovery,
// LSB-first word assembly, start-glitch / parity / stop checking in one FSM.
module uart_rx_frame_check #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  str_glitch
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  state_t                  state, state_next;
  logic [PRESCALE_W-1:0]   presc_q;
  logic                    par_en_q, par_typ_q;
  logic [PRESCALE_W-1:0]   edge_cnt;
  logic [3:0]              bit_cnt;
  logic [DATA_WIDTH-1:0]   word;
  logic                    s0, s1, sampled_bit;

  logic [PRESCALE_W-1:0]   half;
  logic                    at_s0, at_s1, at_s2, end_bit;
  logic                    vote, bit_val, exp_par;
  logic                    dv_next, pe_next, se_next, sg_next;

  always_comb begin
    half    = presc_q >> 1;
    at_s0   = (edge_cnt == half - ONE);
    at_s1   = (edge_cnt == half);
    at_s2   = (edge_cnt == half + ONE);
    end_bit = (edge_cnt == presc_q - ONE);
    vote    = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
    // At P=4 the third sample lands on end-of-bit, so the vote is used before it is registered
    bit_val = at_s2 ? vote : sampled_bit;
    exp_par = par_typ_q ? ~^word : ^word;
  end

  always_comb begin
    state_next = state;
    dv_next    = 1'b0;
    pe_next    = 1'b0;
    se_next    = 1'b0;
    sg_next    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!RX_IN) state_next = START;
      end
      START: begin
        if (end_bit) begin
          if (bit_val) begin
            sg_next    = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (end_bit && (bit_cnt == 4'(DATA_WIDTH - 1)))
          state_next = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (end_bit) begin
          if (bit_val != exp_par) begin
            pe_next    = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (end_bit) begin
          if (bit_val) dv_next = 1'b1;
          else         se_next = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      presc_q     <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      word        <= '0;
      s0          <= 1'b0;
      s1          <= 1'b0;
      sampled_bit <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      str_glitch  <= 1'b0;
    end else begin
      state      <= state_next;
      data_valid <= dv_next;
      par_err    <= pe_next;
      stp_err    <= se_next;
      str_glitch <= sg_next;
      if (dv_next) P_DATA <= word;

      if (state == IDLE) begin
        bit_cnt <= '0;
        // The detecting cycle is edge 0, so the first START cycle is edge 1
        if (!RX_IN) begin
          edge_cnt  <= ONE;
          presc_q   <= prescale;
          par_en_q  <= PAR_EN;
          par_typ_q <= PAR_TYP;
        end else begin
          edge_cnt  <= '0;
        end
      end else begin
        edge_cnt <= end_bit ? '0 : edge_cnt + ONE;
        if (at_s0) s0 <= RX_IN;
        if (at_s1) s1 <= RX_IN;
        if (at_s2) sampled_bit <= vote;
        if (end_bit && (state == DATA)) begin
          word    <= {bit_val, word[DATA_WIDTH-1:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed bench for uart_rx_frame_check: frame timing, error flags,
// majority voting, back-to-back frames and mid-frame reset.
module tb_uart_rx_frame_check;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] prescale;
  logic          PAR_EN, PAR_TYP;
  logic [DW-1:0] P_DATA;
  logic          data_valid, par_err, stp_err, str_glitch;

  int unsigned checks = 0;
  int unsigned passed = 0;

  always #5 CLK = ~CLK;

  uart_rx_frame_check #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .prescale(prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
    .str_glitch(str_glitch)
  );

  // Flag recorder: counts high cycles and the cycle index of the latest pulse
  int unsigned   cyc = 0;
  int unsigned   dv_n = 0, pe_n = 0, se_n = 0, sg_n = 0;
  int unsigned   dv_at = 0, pe_at = 0, se_at = 0, sg_at = 0;
  logic [DW-1:0] dv_word [0:31];
  int unsigned   dv_cyc  [0:31];

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (data_valid) begin
      dv_word[dv_n % 32] = P_DATA;
      dv_cyc[dv_n % 32]  = cyc;
      dv_n  = dv_n + 1;
      dv_at = cyc;
    end
    if (par_err)    begin pe_n = pe_n + 1; pe_at = cyc; end
    if (stp_err)    begin se_n = se_n + 1; se_at = cyc; end
    if (str_glitch) begin sg_n = sg_n + 1; sg_at = cyc; end
  end

  task automatic drive(input logic v);
    @(posedge CLK);
    #1;
    RX_IN = v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1);
  endtask

  // Drives one full frame; config is scrambled after the latching cycle.
  task automatic send_frame(input logic [DW-1:0] data, input int p,
                            input logic pen, input logic ptyp, input logic pbit,
                            input logic stop, input int spike_bit,
                            output int unsigned start);
    int   nb;
    logic v;
    nb = DW + 2 + (pen ? 1 : 0);
    start = 0;
    prescale = PW'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    for (int b = 0; b < nb; b++) begin
      if (b == 0)                    v = 1'b0;
      else if (b <= DW)              v = data[b-1];
      else if (pen && (b == DW + 1)) v = pbit;
      else                           v = stop;
      for (int e = 0; e < p; e++) begin
        if ((spike_bit >= 0) && (b == spike_bit + 1) && (e == p / 2)) drive(~v);
        else drive(v);
        if (b == 0 && e == 0) start = cyc + 1;
        if (b == 0 && e == 1) begin
          prescale = PW'(p + 2);
          PAR_EN   = ~pen;
          PAR_TYP  = ~ptyp;
        end
      end
    end
  endtask

  task automatic test_reset;
    RST = 1'b0; RX_IN = 1'b1; prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (P_DATA !== 8'h00) $display("FAIL reset_pdata: got %h want 00", P_DATA);
    else passed++;
    checks++;
    if ({data_valid, par_err, stp_err, str_glitch} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {data_valid, par_err, stp_err, str_glitch});
    else passed++;
    RST = 1'b1;
    idle(4);
  endtask

  task automatic test_8n1;
    int unsigned s, dv0, err0;
    dv0 = dv_n; err0 = pe_n + se_n + sg_n;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, s);
    idle(12);
    checks++;
    if (dv_n - dv0 !== 1) $display("FAIL 8n1_dv_count: got %0d want 1", dv_n - dv0);
    else passed++;
    checks++;
    if (dv_at - s !== 80) $display("FAIL 8n1_dv_cycle: got %0d want 80", dv_at - s);
    else passed++;
    checks++;
    if (P_DATA !== 8'hA5) $display("FAIL 8n1_pdata: got %h want a5", P_DATA);
    else passed++;
    checks++;
    if (pe_n + se_n + sg_n - err0 !== 0)
      $display("FAIL 8n1_err_flags: got %0d want 0", pe_n + se_n + sg_n - err0);
    else passed++;
  endtask

  task automatic test_parity;
    int unsigned s, dv0, pe0;
    dv0 = dv_n; pe0 = pe_n;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, s);
    idle(12);
    checks++;
    if (pe_n - pe0 !== 1) $display("FAIL parity_count: got %0d want 1", pe_n - pe0);
    else passed++;
    checks++;
    if (pe_at - s !== 160) $display("FAIL parity_cycle: got %0d want 160", pe_at - s);
    else passed++;
    checks++;
    if (dv_n - dv0 !== 0) $display("FAIL parity_no_dv: got %0d want 0", dv_n - dv0);
    else passed++;
    checks++;
    if (P_DATA !== 8'hA5) $display("FAIL parity_pdata_kept: got %h want a5", P_DATA);
    else passed++;
  endtask

  task automatic test_start_glitch;
    int unsigned s, s2, dv0, sg0, other0;
    dv0 = dv_n; sg0 = sg_n; other0 = pe_n + se_n;
    prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    drive(1'b0);
    s = cyc + 1;
    drive(1'b0);
    drive(1'b0);
    idle(14);
    checks++;
    if (sg_n - sg0 !== 1) $display("FAIL glitch_count: got %0d want 1", sg_n - sg0);
    else passed++;
    checks++;
    if (sg_at - s !== 8) $display("FAIL glitch_cycle: got %0d want 8", sg_at - s);
    else passed++;
    checks++;
    if ((dv_n - dv0) + (pe_n + se_n - other0) !== 0)
      $display("FAIL glitch_other_flags: got %0d want 0", (dv_n - dv0) + (pe_n + se_n - other0));
    else passed++;
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, s2);
    idle(12);
    checks++;
    if (dv_n - dv0 !== 1) $display("FAIL glitch_next_dv: got %0d want 1", dv_n - dv0);
    else passed++;
    checks++;
    if (dv_at - s2 !== 80) $display("FAIL glitch_next_cycle: got %0d want 80", dv_at - s2);
    else passed++;
    checks++;
    if (P_DATA !== 8'h96) $display("FAIL glitch_next_pdata: got %h want 96", P_DATA);
    else passed++;
  endtask

  task automatic test_stop_err;
    int unsigned s, s2, dv0, se0;
    dv0 = dv_n; se0 = se_n;
    send_frame(8'hC3, 32, 1'b0, 1'b0, 1'b0, 1'b0, -1, s);
    idle(8);
    checks++;
    if (se_n - se0 !== 1) $display("FAIL stop_count: got %0d want 1", se_n - se0);
    else passed++;
    checks++;
    if (se_at - s !== 320) $display("FAIL stop_cycle: got %0d want 320", se_at - s);
    else passed++;
    checks++;
    if ((dv_n - dv0 !== 0) || (P_DATA !== 8'h96))
      $display("FAIL stop_pdata_kept: got dv=%0d pdata=%h want dv=0 pdata=96", dv_n - dv0, P_DATA);
    else passed++;
    send_frame(8'h5A, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, s2);
    idle(8);
    checks++;
    if (dv_at - s2 !== 320) $display("FAIL stop_next_cycle: got %0d want 320", dv_at - s2);
    else passed++;
    checks++;
    if ((dv_n - dv0 !== 1) || (P_DATA !== 8'h5A))
      $display("FAIL stop_next_pdata: got dv=%0d pdata=%h want dv=1 pdata=5a", dv_n - dv0, P_DATA);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int unsigned s1, s2, dv0, err0;
    dv0 = dv_n; err0 = pe_n + se_n + sg_n;
    send_frame(8'h00, 16, 1'b1, 1'b1, 1'b1, 1'b1, 3, s1);
    send_frame(8'hFF, 16, 1'b1, 1'b1, 1'b1, 1'b1, 3, s2);
    idle(12);
    checks++;
    if (dv_n - dv0 !== 2) $display("FAIL b2b_dv_count: got %0d want 2", dv_n - dv0);
    else passed++;
    checks++;
    if (dv_cyc[dv0 % 32] - s1 !== 176)
      $display("FAIL b2b_first_cycle: got %0d want 176", dv_cyc[dv0 % 32] - s1);
    else passed++;
    checks++;
    if (dv_cyc[(dv0 + 1) % 32] - dv_cyc[dv0 % 32] !== 176)
      $display("FAIL b2b_spacing: got %0d want 176", dv_cyc[(dv0 + 1) % 32] - dv_cyc[dv0 % 32]);
    else passed++;
    checks++;
    if ((dv_word[dv0 % 32] !== 8'h00) || (dv_word[(dv0 + 1) % 32] !== 8'hFF))
      $display("FAIL b2b_words: got %h,%h want 00,ff", dv_word[dv0 % 32], dv_word[(dv0 + 1) % 32]);
    else passed++;
    checks++;
    if (pe_n + se_n + sg_n - err0 !== 0)
      $display("FAIL b2b_err_flags: got %0d want 0", pe_n + se_n + sg_n - err0);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int unsigned s, dv0, err0;
    logic [DW-1:0] d;
    d = 8'h77;
    prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (8) drive(1'b0);
    for (int b = 0; b < 4; b++) repeat (8) drive(d[b]);
    repeat (3) drive(d[4]);
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if (P_DATA !== 8'h00) $display("FAIL midrst_pdata: got %h want 00", P_DATA);
    else passed++;
    checks++;
    if ({data_valid, par_err, stp_err, str_glitch} !== 4'b0000)
      $display("FAIL midrst_flags: got %b want 0000", {data_valid, par_err, stp_err, str_glitch});
    else passed++;
    RX_IN = 1'b1;
    dv0 = dv_n; err0 = pe_n + se_n + sg_n;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    idle(100);
    checks++;
    if ((dv_n - dv0) + (pe_n + se_n + sg_n - err0) !== 0)
      $display("FAIL midrst_no_flag: got %0d want 0", (dv_n - dv0) + (pe_n + se_n + sg_n - err0));
    else passed++;
    send_frame(8'h3E, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, s);
    idle(12);
    checks++;
    if (dv_at - s !== 80) $display("FAIL midrst_next_cycle: got %0d want 80", dv_at - s);
    else passed++;
    checks++;
    if ((dv_n - dv0 !== 1) || (P_DATA !== 8'h3E))
      $display("FAIL midrst_next_pdata: got dv=%0d pdata=%h want dv=1 pdata=3e", dv_n - dv0, P_DATA);
    else passed++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_start_glitch();
    test_stop_err();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
